// File: rtl/ctrl_pkt_arbiter.sv
// ctrl_pkt_arbiter
// Round-robin, packet-granular arbiter. It shares one 64-bit control-packet
// AXI-stream between NUM_REQ UDT control sources. Requester 0 is the handshake
// source. Each granted packet is forwarded whole through a one-deep registered
// output stage.
//
// Optional feature: define CTRL_ARB_HS_PRIORITY_EN to give requester 0 absolute
// priority at arbitration time. A grant to requester 0 then leaves the
// round-robin pointer untouched. A locked packet is never preempted in either
// build.
//
// Ports
//   core_clk, core_rst : clock, asynchronous active-high reset
//   s_tdata/s_tkeep/s_tvalid/s_tlast : requester streams, requester i in slice i
//   s_tready           : per-requester ready; only the locked requester can be high
//   m_tdata/m_tkeep/m_tvalid/m_tlast, m_tready : registered output stream
//   grant_id           : current or most recent grant
//   busy               : a packet is locked
//   overrun            : one-cycle pulse when a packet exceeds MAX_BEATS beats
module ctrl_pkt_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic                   core_clk,
  input  logic                   core_rst,
  input  logic [NUM_REQ*64-1:0]  s_tdata,
  input  logic [NUM_REQ*8-1:0]   s_tkeep,
  input  logic [NUM_REQ-1:0]     s_tvalid,
  input  logic [NUM_REQ-1:0]     s_tlast,
  output logic [NUM_REQ-1:0]     s_tready,
  output logic [63:0]            m_tdata,
  output logic [7:0]             m_tkeep,
  output logic                   m_tvalid,
  output logic                   m_tlast,
  input  logic                   m_tready,
  output logic [2:0]             grant_id,
  output logic                   busy,
  output logic                   overrun
);

  localparam int unsigned GW = 3;
  localparam int unsigned CW = 8;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          state;
  logic [GW-1:0]   last_grant;
  logic [CW-1:0]   beat_cnt;

  logic            sel_valid_c;
  logic            sel_last_c;
  logic [63:0]     sel_data_c;
  logic [7:0]      sel_keep_c;
  logic            out_ready_c;
  logic            accept_c;
  logic            arb_found_c;
  logic [GW-1:0]   arb_pick_c;

  // Route the granted requester's stream; ready is combinational so the
  // source stalls in the same cycle the output stage is blocked.
  always_comb begin
    sel_valid_c = 1'b0;
    sel_last_c  = 1'b0;
    sel_data_c  = '0;
    sel_keep_c  = '0;
    s_tready    = '0;
    out_ready_c = !m_tvalid || m_tready;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_id == GW'(i)) begin
        sel_valid_c = s_tvalid[i];
        sel_last_c  = s_tlast[i];
        sel_data_c  = s_tdata[64*i +: 64];
        sel_keep_c  = s_tkeep[8*i +: 8];
        s_tready[i] = (state == LOCK) && out_ready_c;
      end
    end
    accept_c = (state == LOCK) && sel_valid_c && out_ready_c;
  end

  // Round-robin search: first valid requester starting after last_grant.
  always_comb begin
    arb_found_c = 1'b0;
    arb_pick_c  = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      for (int j = 0; j < int'(NUM_REQ); j++) begin
        if (!arb_found_c && s_tvalid[j] &&
            (j == (int'(last_grant) + k) % int'(NUM_REQ))) begin
          arb_found_c = 1'b1;
          arb_pick_c  = GW'(j);
        end
      end
    end
`ifdef CTRL_ARB_HS_PRIORITY_EN
    // Handshake traffic overrides the pointer whenever it is pending.
    if (s_tvalid[0]) begin
      arb_found_c = 1'b1;
      arb_pick_c  = '0;
    end
`endif
  end

  // Arbitration FSM, beat counter and registered output stage.
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      busy       <= 1'b0;
      overrun    <= 1'b0;
      beat_cnt   <= '0;
      m_tdata    <= '0;
      m_tkeep    <= '0;
      m_tvalid   <= 1'b0;
      m_tlast    <= 1'b0;
    end else begin
      overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (arb_found_c) begin
            grant_id <= arb_pick_c;
            busy     <= 1'b1;
            beat_cnt <= '0;
            state    <= LOCK;
          end
        end
        LOCK: begin
          if (accept_c) begin
            if (beat_cnt != {CW{1'b1}}) begin
              beat_cnt <= beat_cnt + CW'(1);
            end
            // Fires once, on the beat that moves the count past MAX_BEATS.
            if ((beat_cnt == CW'(MAX_BEATS)) && (beat_cnt != {CW{1'b1}})) begin
              overrun <= 1'b1;
            end
            if (sel_last_c) begin
`ifdef CTRL_ARB_HS_PRIORITY_EN
              if (grant_id != '0) begin
                last_grant <= grant_id;
              end
`else
              last_grant <= grant_id;
`endif
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (accept_c) begin
        m_tdata  <= sel_data_c;
        m_tkeep  <= sel_keep_c;
        m_tlast  <= sel_last_c;
        m_tvalid <= 1'b1;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ctrl_pkt_arbiter.sv
// Directed testbench for ctrl_pkt_arbiter (NUM_REQ=4, MAX_BEATS=16).
module tb_ctrl_pkt_arbiter;

  localparam int unsigned NUM_REQ = 4;

  logic                  core_clk = 1'b0;
  logic                  core_rst;
  logic [NUM_REQ*64-1:0] s_tdata;
  logic [NUM_REQ*8-1:0]  s_tkeep;
  logic [NUM_REQ-1:0]    s_tvalid;
  logic [NUM_REQ-1:0]    s_tlast;
  logic [NUM_REQ-1:0]    s_tready;
  logic [63:0]           m_tdata;
  logic [7:0]            m_tkeep;
  logic                  m_tvalid;
  logic                  m_tlast;
  logic                  m_tready;
  logic [2:0]            grant_id;
  logic                  busy;
  logic                  overrun;

  ctrl_pkt_arbiter #(.NUM_REQ(4), .MAX_BEATS(16)) dut (
    .core_clk (core_clk),
    .core_rst (core_rst),
    .s_tdata  (s_tdata),
    .s_tkeep  (s_tkeep),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tkeep  (m_tkeep),
    .m_tvalid (m_tvalid),
    .m_tlast  (m_tlast),
    .m_tready (m_tready),
    .grant_id (grant_id),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 core_clk = ~core_clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge core_clk) cyc <= cyc + 1;

  // Output sink: one entry per completed output transfer.
  logic [63:0] sk_data[$];
  logic [7:0]  sk_keep[$];
  logic        sk_last[$];
  int          sk_cyc[$];

  always @(negedge core_clk) begin
    if (!core_rst && m_tvalid && m_tready) begin
      sk_data.push_back(m_tdata);
      sk_keep.push_back(m_tkeep);
      sk_last.push_back(m_tlast);
      sk_cyc.push_back(cyc);
    end
  end

  int ovr_cnt  = 0;
  int ovr_beat = -1;

  always @(negedge core_clk) begin
    if (overrun) begin
      ovr_cnt  = ovr_cnt + 1;
      ovr_beat = int'(m_tdata[15:0]);
    end
  end

  function automatic logic [63:0] pat(input int src, input int beat);
    return {8'hA5, 8'(src), 32'h0, 16'(beat)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sink_clear();
    sk_data.delete();
    sk_keep.delete();
    sk_last.delete();
    sk_cyc.delete();
  endtask

  task automatic chk_beat(input string tag, input int idx, input int src,
                          input int beat, input logic [7:0] keep, input logic last);
    if (idx >= sk_data.size()) begin
      chk($sformatf("%s_cnt%0d", tag, idx), 64'(sk_data.size()), 64'(idx + 1));
    end else begin
      chk($sformatf("%s_data%0d", tag, idx), sk_data[idx], pat(src, beat));
      chk($sformatf("%s_keep%0d", tag, idx), 64'(sk_keep[idx]), 64'(keep));
      chk($sformatf("%s_last%0d", tag, idx), 64'(sk_last[idx]), 64'(last));
    end
  endtask

  // Bounded wait for s_tready[src] seen at a falling edge.
  task automatic wait_ready(input int src);
    int t;
    t = 0;
    do begin
      @(negedge core_clk);
      t++;
    end while (!s_tready[src] && t < 200);
    if (!s_tready[src]) chk($sformatf("ready_timeout_r%0d", src), 64'(s_tready[src]), 64'd1);
  endtask

  // Drive one packet from requester src; returns just after the last beat's edge.
  task automatic send_pkt(input int src, input int n, input logic [7:0] last_keep);
    for (int b = 0; b < n; b++) begin
      s_tdata[64*src +: 64] = pat(src, b);
      s_tkeep[8*src +: 8]   = (b == n - 1) ? last_keep : 8'hFF;
      s_tlast[src]          = (b == n - 1);
      s_tvalid[src]         = 1'b1;
      wait_ready(src);
      @(posedge core_clk);
      #1;
    end
    s_tvalid[src] = 1'b0;
    s_tlast[src]  = 1'b0;
  endtask

  task automatic do_reset();
    core_rst = 1'b1;
    s_tvalid = '0;
    s_tlast  = '0;
    m_tready = 1'b1;
    repeat (2) @(posedge core_clk);
    #1;
    core_rst = 1'b0;
    sink_clear();
  endtask

  task automatic drain();
    repeat (4) @(negedge core_clk);
  endtask

  int  t0;
  int  exp_src;
  bit  found;

  initial begin
    core_rst = 1'b1;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tvalid = '0;
    s_tlast  = '0;
    m_tready = 1'b1;
    repeat (2) @(posedge core_clk);
    @(negedge core_clk);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tdata",  m_tdata,       64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_grant",    64'(grant_id), 64'd0);
    chk("rst_busy",     64'(busy),     64'd0);
    @(posedge core_clk);
    #1;
    core_rst = 1'b0;

    // 1: requester 2, three beats, keep FF,FF,0F.
    sink_clear();
    t0 = cyc;
    send_pkt(2, 3, 8'h0F);
    @(negedge core_clk);
    chk("t1_busy_after", 64'(busy), 64'd0);
    chk("t1_grant", 64'(grant_id), 64'd2);
    drain();
    chk("t1_count", 64'(sk_data.size()), 64'd3);
    if (sk_cyc.size() > 0) chk("t1_latency", 64'(sk_cyc[0] - t0), 64'd2);
    chk_beat("t1", 0, 2, 0, 8'hFF, 1'b0);
    chk_beat("t1", 1, 2, 1, 8'hFF, 1'b0);
    chk_beat("t1", 2, 2, 2, 8'h0F, 1'b1);

    // 2: all four requesters offer back-to-back single-beat packets.
    do_reset();
    fork
      begin send_pkt(0, 1, 8'hFF); send_pkt(0, 1, 8'hFF); end
      begin send_pkt(1, 1, 8'hFF); send_pkt(1, 1, 8'hFF); end
      begin send_pkt(2, 1, 8'hFF); send_pkt(2, 1, 8'hFF); end
      begin send_pkt(3, 1, 8'hFF); send_pkt(3, 1, 8'hFF); end
    join
    drain();
    chk("t2_count", 64'(sk_data.size()), 64'd8);
    for (int p = 0; p < 8; p++) chk_beat("t2", p, p % 4, 0, 8'hFF, 1'b1);
    for (int p = 1; p < 8 && p < sk_cyc.size(); p++)
      chk($sformatf("t2_gap%0d", p), 64'(sk_cyc[p] - sk_cyc[p-1]), 64'd2);

    // 3: requester 1, four beats, downstream stalls five cycles on beat 2.
    do_reset();
    fork
      send_pkt(1, 4, 8'hFF);
      begin
        found = 1'b0;
        for (int t = 0; t < 50 && !found; t++) begin
          @(posedge core_clk);
          #2;
          if (m_tvalid && m_tdata == pat(1, 1)) found = 1'b1;
        end
        chk("t3_stall_found", 64'(found), 64'd1);
        m_tready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge core_clk);
          chk($sformatf("t3_sready%0d", s), 64'(s_tready[1]), 64'd0);
          chk($sformatf("t3_hold%0d", s),   m_tdata,          pat(1, 1));
          chk($sformatf("t3_valid%0d", s),  64'(m_tvalid),    64'd1);
        end
        chk("t3_busy", 64'(busy), 64'd1);
        @(posedge core_clk);
        #1;
        m_tready = 1'b1;
      end
    join
    drain();
    chk("t3_count", 64'(sk_data.size()), 64'd4);
    for (int p = 0; p < 4; p++) chk_beat("t3", p, 1, p, 8'hFF, p == 3);

    // 4: requester 3, 20 beats against MAX_BEATS=16.
    do_reset();
    ovr_cnt  = 0;
    ovr_beat = -1;
    send_pkt(3, 20, 8'hFF);
    drain();
    chk("t4_ovr_cnt",  64'(ovr_cnt),  64'd1);
    chk("t4_ovr_beat", 64'(ovr_beat), 64'd16);
    chk("t4_count", 64'(sk_data.size()), 64'd20);
    for (int p = 0; p < 20; p++) chk_beat("t4", p, 3, p, 8'hFF, p == 19);

    // 5: reset asserted while beat 2 of a five-beat packet is on the output.
    do_reset();
    @(posedge core_clk);
    #1;
    s_tdata[128 +: 64] = pat(2, 0);
    s_tkeep[16 +: 8]   = 8'hFF;
    s_tlast[2]         = 1'b0;
    s_tvalid[2]        = 1'b1;
    wait_ready(2);
    @(posedge core_clk);
    #1;
    s_tdata[128 +: 64] = pat(2, 1);
    wait_ready(2);
    @(posedge core_clk);
    #2;
    chk("t5_pre_data", m_tdata, pat(2, 1));
    core_rst = 1'b1;
    s_tvalid = '0;
    #1;
    chk("t5_rst_valid",  64'(m_tvalid), 64'd0);
    chk("t5_rst_data",   m_tdata,       64'd0);
    chk("t5_rst_keep",   64'(m_tkeep),  64'd0);
    chk("t5_rst_busy",   64'(busy),     64'd0);
    chk("t5_rst_sready", 64'(s_tready), 64'd0);
    sink_clear();
    @(posedge core_clk);
    #1;
    core_rst = 1'b0;
    sink_clear();
    fork
      send_pkt(0, 1, 8'hFF);
      send_pkt(2, 1, 8'hFF);
    join
    drain();
    chk("t5_count", 64'(sk_data.size()), 64'd2);
    chk_beat("t5", 0, 0, 0, 8'hFF, 1'b1);
    chk_beat("t5", 1, 2, 0, 8'hFF, 1'b1);

    // 6: last_grant=0, requesters 0 and 1 both pending.
    do_reset();
    send_pkt(0, 1, 8'hFF);
    drain();
    sink_clear();
    fork
      send_pkt(0, 1, 8'hFF);
      send_pkt(1, 1, 8'hFF);
    join
    drain();
`ifdef CTRL_ARB_HS_PRIORITY_EN
    exp_src = 0;
`else
    exp_src = 1;
`endif
    chk("t6_count", 64'(sk_data.size()), 64'd2);
    chk_beat("t6", 0, exp_src, 0, 8'hFF, 1'b1);
    chk_beat("t6", 1, 1 - exp_src, 0, 8'hFF, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
